i2c_reg_target: RTL and testbench

- I2C target (responder) holding a small register file, addressed by one pointer byte.
- Serves the far end of our I2C master: the master writes a pointer, then streams data writes, or issues a repeated START and streams reads.
- SCL and SDA are oversampled on the system clock; SDA is driven open-drain (low or Z only).
- Local logic gets a host port for direct register access and a strobe on every bus write.

---
 rtl/i2c_reg_target.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// I2C target with a pointer-addressed register file and a host access port.
// Optional: define I2C_GENCALL_EN to also accept general-call writes (address byte 0x00).
module i2c_reg_target #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDRESS = 7,
  parameter logic [ADDRESS-1:0] OWN_ADDR = 7'h50,
  parameter int NUM_REGS = 16,
  localparam int IW = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  input  logic                  host_we,
  input  logic [IW-1:0]         host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  wr_strobe,
  output logic [IW-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy
);

  localparam int DW = DATA_WIDTH;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          rw_q, rw_d;
  logic          rbit_q, rbit_d;
  logic          strb_q, strb_d;
  logic [IW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];

  logic          scl_rise, scl_fall, bus_start, bus_stop, match;
  logic [IW-1:0] ptr_inc;
  logic [DW-1:0] rd_byte, rd_next;

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign bus_start = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign bus_stop  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign ptr_inc   = ptr_q + IW'(1);
  assign rd_byte   = regs_q[ptr_q];
  assign rd_next   = regs_q[ptr_inc];

`ifdef I2C_GENCALL_EN
  assign match = (sh_q[DW-1:DW-ADDRESS] == OWN_ADDR) || (sh_q == '0);
`else
  assign match = (sh_q[DW-1:DW-ADDRESS] == OWN_ADDR);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    rbit_d  = rbit_q;
    strb_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    regs_d  = regs_q;
    if (host_we) regs_d[host_addr] = host_wdata;
    if (bus_stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      cnt_d   = '0;
    end else if (bus_start) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            sh_d  = {sh_q[DW-2:0], sda_s2_q};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            oe_d  = 1'b1;
            if (state_q == ADDR) begin
              state_d = match ? ADDR_ACK : IGNORE;
              oe_d    = match;
              busy_d  = busy_q | match;
              rw_d    = sh_q[0];
            end else if (state_q == PTR) begin
              state_d = PTR_ACK;
              ptr_d   = sh_q[IW-1:0];
            end else begin
              state_d = WDATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              sh_d    = rd_byte;
              oe_d    = ~rd_byte[DW-1];
              state_d = RDATA;
            end else begin
              oe_d    = 1'b0;
              state_d = PTR;
            end
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = WDATA;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            oe_d           = 1'b0;
            regs_d[ptr_q]  = sh_q;
            strb_d         = 1'b1;
            waddr_d        = ptr_q;
            wdata_d        = sh_q;
            ptr_d          = ptr_inc;
            state_d        = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = '0;
              state_d = RDATA_ACK;
            end else begin
              sh_d = {sh_q[DW-2:0], 1'b0};
              oe_d = ~sh_q[DW-2];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            rbit_d = sda_s2_q;
          end else if (scl_fall) begin
            ptr_d = ptr_inc;
            if (!rbit_q) begin
              sh_d    = rd_next;
              oe_d    = ~rd_next[DW-1];
              state_d = RDATA;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      ptr_q    <= '0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      rw_q     <= 1'b0;
      rbit_q   <= 1'b0;
      strb_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      ptr_q    <= ptr_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      rw_q     <= rw_d;
      rbit_q   <= rbit_d;
      strb_q   <= strb_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      regs_q   <= regs_d;
    end
  end

  // Gate with rst so the bus is freed in the very cycle reset rises
  assign sda        = (oe_q && !rst) ? 1'b0 : 1'bz;
  assign host_rdata = regs_q[host_addr];
  assign wr_strobe  = strb_q;
  assign wr_addr    = waddr_q;
  assign wr_data    = wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bus-master bench for i2c_reg_target with a write-strobe scoreboard.
module tb_i2c_reg_target;

  localparam time Q = 50ns;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_reg_target dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  logic [11:0] sb[$];
  logic [11:0] sb_exp;
  logic watch = 1'b0;
  logic spur = 1'b0;
  logic bsy = 1'b0;
  logic gen_en;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL strobe_unexpected: observed %h expected none",
               {wr_addr, wr_data});
      end else begin
        sb_exp = sb.pop_front();
        assert ({wr_addr, wr_data} === sb_exp) else begin
          errors++;
          $error("FAIL strobe: observed %h expected %h",
                 {wr_addr, wr_data}, sb_exp);
        end
      end
    end
    if (watch) begin
      if (sda === 1'b0 && !m_low) spur = 1'b1;
      if (busy) bsy = 1'b1;
    end
  end

  task automatic m_start();
    m_low = 1'b0; #Q; scl = 1'b1; #Q;
    m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic m_stop();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  task automatic wbit(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(ack);
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    sb.push_back({a, d});
  endtask

  logic       ack;
  logic [7:0] rd;

  initial begin
    rst = 1'b1; scl = 1'b1; m_low = 1'b0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
`ifdef I2C_GENCALL_EN
    gen_en = 1'b1;
`else
    gen_en = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #20;
    check("rst_busy", busy, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_sda", sda, 1);
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i); #1;
      check("rst_reg", host_rdata, 0);
    end

    m_start();
    wbyte(8'hA0, ack); check("w_addr_ack", ack, 0);
    wbyte(8'h03, ack); check("w_ptr_ack", ack, 0);
    push(4'd3, 8'hA5);
    wbyte(8'hA5, ack); check("w_d0_ack", ack, 0);
    push(4'd4, 8'h5A);
    wbyte(8'h5A, ack); check("w_d1_ack", ack, 0);
    check("w_busy", busy, 1);
    m_stop(); #Q;
    check("w_busy_stop", busy, 0);
    check("w_strobes", strobes, 2);
    host_addr = 4'd3; #1; check("w_reg3", host_rdata, 8'hA5);
    host_addr = 4'd4; #1; check("w_reg4", host_rdata, 8'h5A);

    m_start();
    wbyte(8'hA0, ack); check("r_addr_ack", ack, 0);
    wbyte(8'h03, ack); check("r_ptr_ack", ack, 0);
    m_start();
    wbyte(8'hA1, ack); check("r_raddr_ack", ack, 0);
    rbyte(rd, 1'b0); check("r_byte0", rd, 8'hA5);
    rbyte(rd, 1'b1); check("r_byte1", rd, 8'h5A);
    check("r_sda_nack", sda, 1);
    m_stop(); #Q;
    check("r_busy_stop", busy, 0);

    watch = 1'b1;
    m_start();
    wbyte(8'hA2, ack); check("x_addr_nack", ack, 1);
    wbyte(8'h55, ack); check("x_data_nack", ack, 1);
    m_stop(); #Q;
    watch = 1'b0;
    check("x_sda_z", spur, 0);
    check("x_busy", bsy, 0);
    check("x_strobes", strobes, 2);

    m_start();
    wbyte(8'hA0, ack); check("p_addr_ack", ack, 0);
    wbyte(8'h0F, ack); check("p_ptr_ack", ack, 0);
    push(4'd15, 8'h11);
    wbyte(8'h11, ack); check("p_d0_ack", ack, 0);
    push(4'd0, 8'h22);
    wbyte(8'h22, ack); check("p_d1_ack", ack, 0);
    m_stop(); #Q;
    host_addr = 4'd15; #1; check("p_reg15", host_rdata, 8'h11);
    host_addr = 4'd0; #1; check("p_reg0", host_rdata, 8'h22);

    m_start();
    wbyte(8'h00, ack); check("g_addr_ack", ack, {31'd0, ~gen_en});
    wbyte(8'h02, ack); check("g_ptr_ack", ack, {31'd0, ~gen_en});
    if (gen_en) push(4'd2, 8'h77);
    wbyte(8'h77, ack); check("g_d_ack", ack, {31'd0, ~gen_en});
    m_stop(); #Q;
    host_addr = 4'd2; #1;
    check("g_reg2", host_rdata, gen_en ? 8'h77 : 8'h00);
    m_start();
    wbyte(8'h01, ack); check("g_read_nack", ack, 1);
    m_stop(); #Q;

    @(posedge clk); #1;
    host_we = 1'b1; host_addr = 4'd5; host_wdata = 8'hC3;
    @(posedge clk); #1;
    host_we = 1'b0; #1;
    check("h_reg5", host_rdata, 8'hC3);
    host_addr = 4'd4; #1; check("h_reg4_kept", host_rdata, 8'h5A);

    m_start();
    wbyte(8'hA0, ack); check("z_addr_ack", ack, 0);
    wbyte(8'h00, ack); check("z_ptr_ack", ack, 0);
    m_start();
    wbyte(8'hA1, ack); check("z_raddr_ack", ack, 0);
    check("z_drive0", sda, 0);
    rst = 1'b1; #1;
    check("z_sda_rst", sda, 1);
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i); #1;
      check("z_reg", host_rdata, 0);
    end
    check("z_busy", busy, 0);
    m_low = 1'b0; scl = 1'b1; #Q;
    rst = 1'b0; #Q;
    check("z_sda_after", sda, 1);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
